// File: rtl/muldiv_unit.sv
// muldiv_unit: pipelined integer multiplier plus early-out radix-2 divider
// sharing one tagged result port; multiply results win output arbitration.
module muldiv_unit #(
    parameter int WIDTH      = 64,
    parameter int MUL_STAGES = 2,
    parameter int TID_W      = 3,
    parameter int WORD_OPS   = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic             word_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic [TID_W-1:0] trans_id_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [TID_W-1:0] trans_id_o
);
    localparam bit WOPS = (WORD_OPS != 0) && (WIDTH == 64);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
        return WIDTH'($signed(x));
    endfunction

    state_e state_q, state_d;
    logic accept, word, mul_fire, mo_v, out_fire;
    logic [WIDTH-1:0] mo_r, mul_res;
    logic [TID_W-1:0] mo_t;
    logic sa, sb;
    logic signed [2*WIDTH-1:0] ma, mb;
    logic [2*WIDTH-1:0] prod;

    assign ready_o  = state_q == IDLE;
    assign accept   = valid_i & ready_o & ~flush_i;
    assign word     = word_i & WOPS;
    assign mul_fire = accept & ~op_i[2];
    assign sa       = op_i == 3'd1 || op_i == 3'd2;
    assign sb       = op_i == 3'd1;
    assign ma       = {{WIDTH{sa & operand_a_i[WIDTH-1]}}, operand_a_i};
    assign mb       = {{WIDTH{sb & operand_b_i[WIDTH-1]}}, operand_b_i};
    assign prod     = ma * mb;
    assign mul_res  = op_i[1:0] != 2'd0 ? prod[2*WIDTH-1:WIDTH]
                    : word ? sext32(prod[31:0]) : prod[WIDTH-1:0];

    // The output register is the last multiplier stage, so MUL_STAGES-1 internal stages remain.
    generate
        if (MUL_STAGES > 1) begin : g_pipe
            logic             v_q [MUL_STAGES-1];
            logic [WIDTH-1:0] r_q [MUL_STAGES-1];
            logic [TID_W-1:0] t_q [MUL_STAGES-1];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < MUL_STAGES-1; i++) begin
                        v_q[i] <= 1'b0;
                        r_q[i] <= '0;
                        t_q[i] <= '0;
                    end
                end else begin
                    v_q[0] <= mul_fire;
                    r_q[0] <= mul_res;
                    t_q[0] <= trans_id_i;
                    for (int i = 1; i < MUL_STAGES-1; i++) begin
                        v_q[i] <= v_q[i-1] & ~flush_i;
                        r_q[i] <= r_q[i-1];
                        t_q[i] <= t_q[i-1];
                    end
                end
            end
            assign mo_v = v_q[MUL_STAGES-2] & ~flush_i;
            assign mo_r = r_q[MUL_STAGES-2];
            assign mo_t = t_q[MUL_STAGES-2];
        end else begin : g_comb
            assign mo_v = mul_fire;
            assign mo_r = mul_res;
            assign mo_t = trans_id_i;
        end
    endgenerate

    logic dsgn, neg_a, neg_b, bz, ovf, early;
    logic [WIDTH-1:0] ea, eb, abs_a, abs_b, min_neg;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, qf, rf, dr, div_res;
    logic [WIDTH:0] sh, diff;
    logic [CW-1:0] cnt_q, cnt_d;
    logic negq_q, negq_d, negr_q, negr_d, remop_q, remop_d, wd_q, wd_d;
    logic [TID_W-1:0] tid_q, tid_d;

    assign dsgn    = ~op_i[0];
    assign ea      = word ? (dsgn ? sext32(operand_a_i[31:0]) : WIDTH'(operand_a_i[31:0])) : operand_a_i;
    assign eb      = word ? (dsgn ? sext32(operand_b_i[31:0]) : WIDTH'(operand_b_i[31:0])) : operand_b_i;
    assign neg_a   = dsgn & ea[WIDTH-1];
    assign neg_b   = dsgn & eb[WIDTH-1];
    assign abs_a   = neg_a ? -ea : ea;
    assign abs_b   = neg_b ? -eb : eb;
    assign min_neg = word ? sext32(32'h8000_0000) : {1'b1, {(WIDTH-1){1'b0}}};
    assign bz      = eb == '0;
    assign ovf     = dsgn && ea == min_neg && eb == '1;
    assign early   = bz | ovf | (ea == '0);
    assign sh      = {rem_q, quo_q[WIDTH-1]};
    assign diff    = sh - {1'b0, dvs_q};
    assign qf      = negq_q ? -quo_q : quo_q;
    assign rf      = negr_q ? -rem_q : rem_q;
    assign dr      = remop_q ? rf : qf;
    assign div_res = wd_q ? sext32(dr[31:0]) : dr;
    assign out_fire = ~flush_i & (mo_v | state_q == DONE);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        remop_d = remop_q;
        wd_d    = wd_q;
        tid_d   = tid_q;
        if (state_q == IDLE && accept && op_i[2]) begin
            dvs_d   = abs_b;
            negq_d  = early ? 1'b0 : neg_a ^ neg_b;
            negr_d  = early ? 1'b0 : neg_a;
            remop_d = op_i[1];
            wd_d    = word;
            tid_d   = trans_id_i;
            cnt_d   = word ? CW'(31) : CW'(WIDTH-1);
            quo_d   = bz ? '1 : ovf ? ea : early ? '0 : word ? abs_a << 32 : abs_a;
            rem_d   = bz ? ea : '0;
            state_d = early ? DONE : CALC;
        end else if (state_q == CALC) begin
            rem_d   = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
            quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == '0 ? DONE : CALC;
        end else if (state_q == DONE && !mo_v) begin
            state_d = IDLE;
        end
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            remop_q <= 1'b0;
            wd_q    <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            remop_q <= remop_d;
            wd_q    <= wd_d;
            tid_q   <= tid_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            result_o   <= '0;
            trans_id_o <= '0;
        end else begin
            valid_o <= out_fire;
            if (out_fire) begin
                result_o   <= mo_v ? mo_r : div_res;
                trans_id_o <= mo_v ? mo_t : tid_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench; a 2-stage instance covers most cases,
// a 4-stage instance covers the multiply/divide output collision.
module tb_muldiv_unit;
    typedef struct {
        logic [63:0] r;
        logic [2:0]  id;
        int          due;
    } exp_t;

    logic clk = 0, rst_n = 0, flush = 0, vld = 0, vld1 = 0, word = 0;
    logic [2:0] op = 0, tid = 0;
    logic [63:0] a = 0, b = 0;
    logic rdy, vo, rdy1, vo1;
    logic [63:0] res, res1;
    logic [2:0] tido, tido1;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q0[$], q1[$];

    muldiv_unit u0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld), .ready_o(rdy),
        .op_i(op), .word_i(word), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tid),
        .valid_o(vo), .result_o(res), .trans_id_o(tido)
    );

    muldiv_unit #(.MUL_STAGES(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vld1), .ready_o(rdy1),
        .op_i(op), .word_i(word), .operand_a_i(a), .operand_b_i(b), .trans_id_i(tid),
        .valid_o(vo1), .result_o(res1), .trans_id_o(tido1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic mon(input bit u, input logic [63:0] r, input logic [2:0] t);
        exp_t e;
        checks++;
        if ((u ? q1.size() : q0.size()) == 0) begin
            errors++;
            $display("FAIL unexpected_out dut%0d: got id=%0d res=%h cyc=%0d expected no output", u, t, r, cyc);
            return;
        end
        if (u) e = q1.pop_front();
        else e = q0.pop_front();
        if (r !== e.r || t !== e.id || cyc !== e.due) begin
            errors++;
            $display("FAIL result dut%0d: got id=%0d res=%h cyc=%0d expected id=%0d res=%h cyc=%0d",
                     u, t, r, cyc, e.id, e.r, e.due);
        end
    endtask

    always @(negedge clk) if (rst_n && vo) mon(1'b0, res, tido);
    always @(negedge clk) if (rst_n && vo1) mon(1'b1, res1, tido1);

    task automatic issue(input bit u, input bit push, input logic [2:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y, input logic [2:0] id,
                         input logic [63:0] e, input int lat);
        exp_t t;
        op = o; word = w; a = x; b = y; tid = id;
        if (u) vld1 = 1; else vld = 1;
        t.r = e; t.id = id; t.due = cyc + lat;
        if (push) begin
            if (u) q1.push_back(t);
            else q0.push_back(t);
        end
        @(posedge clk); #1;
        vld = 0; vld1 = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rdy && rdy1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(rdy && rdy1)) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=%b/%b expected 1/1", rdy, rdy1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(vo), 0);
        chk("rst_result", res, 0);
        chk("rst_tid", 64'(tido), 0);
        chk("rst_ready", 64'(rdy), 1);
        rst_n = 1;
        @(posedge clk); #1;
        // multiplies, 2-cycle latency
        issue(0, 1, 0, 0, 64'd7, -64'sd3, 1, 64'hFFFF_FFFF_FFFF_FFEB, 2);
        issue(0, 1, 3, 0, '1, '1, 2, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        issue(0, 1, 1, 0, '1, '1, 3, 64'd0, 2);
        issue(0, 1, 2, 0, '1, '1, 4, '1, 2);
        issue(0, 1, 1, 0, 64'h4000_0000_0000_0000, 64'd4, 5, 64'd1, 2);
        issue(0, 1, 0, 1, 64'hDEAD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 6, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        issue(0, 1, 3, 1, '1, '1, 7, 64'hFFFF_FFFF_FFFF_FFFE, 2);
        issue(0, 1, 0, 0, 64'd2, 64'd3, 1, 64'd6, 2);
        issue(0, 1, 0, 0, 64'd4, 64'd5, 2, 64'd20, 2);
        issue(0, 1, 0, 0, 64'd6, 64'd7, 3, 64'd42, 2);
        // full-length and word divides
        issue(0, 1, 4, 0, -64'sd20, 64'd3, 1, -64'sd6, 66); wait_ready();
        issue(0, 1, 6, 0, -64'sd20, 64'd3, 2, -64'sd2, 66); wait_ready();
        issue(0, 1, 4, 0, 64'd20, -64'sd3, 3, -64'sd6, 66); wait_ready();
        issue(0, 1, 6, 0, 64'd20, -64'sd3, 4, 64'd2, 66); wait_ready();
        issue(0, 1, 7, 0, 64'd100, 64'd7, 5, 64'd2, 66); wait_ready();
        issue(0, 1, 5, 1, 64'h1_0000_0010, 64'd4, 6, 64'd4, 34); wait_ready();
        issue(0, 1, 4, 1, 64'h0000_0000_FFFF_FFEC, 64'd3, 7, -64'sd6, 34); wait_ready();
        // early-out divides
        issue(0, 1, 5, 0, 64'd123, 64'd0, 1, '1, 2); wait_ready();
        issue(0, 1, 6, 0, 64'h8000_0000_0000_0000, '1, 2, 64'd0, 2); wait_ready();
        issue(0, 1, 4, 0, 64'h8000_0000_0000_0000, '1, 3, 64'h8000_0000_0000_0000, 2); wait_ready();
        issue(0, 1, 4, 0, 64'd0, 64'd5, 4, 64'd0, 2); wait_ready();
        issue(0, 1, 6, 0, 64'd5, 64'd0, 5, 64'd5, 2); wait_ready();
        // multiply/divide collision on the 4-stage instance
        issue(1, 1, 0, 0, 64'd5, 64'd5, 5, 64'd25, 4);
        @(posedge clk); #1;
        issue(1, 1, 5, 0, 64'd9, 64'd0, 6, '1, 3);
        @(posedge clk); #1;
        chk("coll_ready_busy", 64'(rdy1), 0);
        @(posedge clk); #1;
        chk("coll_ready_free", 64'(rdy1), 1);
        wait_ready();
        // flush during CALC
        issue(0, 0, 4, 0, 64'd1000, 64'd7, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1; flush = 1;
        @(posedge clk); #1; flush = 0;
        chk("flush_calc_ready", 64'(rdy), 1);
        chk("flush_calc_valid", 64'(vo), 0);
        // flush during DONE
        issue(0, 0, 5, 0, 64'd9, 64'd0, 1, 0, 0);
        flush = 1;
        @(posedge clk); #1; flush = 0;
        chk("flush_done_valid", 64'(vo), 0);
        chk("flush_done_ready", 64'(rdy), 1);
        // input in a flush cycle is dropped; an in-flight multiply is killed
        flush = 1;
        issue(0, 0, 0, 0, 64'd3, 64'd3, 2, 0, 0);
        flush = 0;
        issue(0, 0, 0, 0, 64'd3, 64'd3, 3, 0, 0);
        flush = 1;
        @(posedge clk); #1; flush = 0;
        repeat (4) @(posedge clk);
        #1;
        issue(0, 1, 0, 0, 64'd3, 64'd3, 2, 64'd9, 2);
        repeat (3) @(posedge clk);
        #1;
        // reset mid-CALC
        issue(0, 0, 4, 0, 64'd1000, 64'd7, 6, 0, 0);
        repeat (5) @(posedge clk);
        #1; rst_n = 0;
        #1;
        chk("rst_mid_valid", 64'(vo), 0);
        chk("rst_mid_result", res, 0);
        chk("rst_mid_tid", 64'(tido), 0);
        chk("rst_mid_ready", 64'(rdy), 1);
        @(posedge clk); #1; rst_n = 1;
        @(posedge clk); #1;
        issue(0, 1, 0, 0, 64'h10, 64'h10, 4, 64'h100, 2);
        for (int n = 0; n < 300 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clk);
        #1;
        chk("drain", 64'(q0.size() + q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
